// File: rtl/md5_block_feeder_if.sv
// Host byte stream in, 128-bit beats with one-hot strobes out, plus core completion.
// master = host/core side, slave = md5_block_feeder.
interface md5_block_feeder_if;
   logic [7:0]   s_data;
   logic         s_valid;
   logic         s_last;
   logic         s_ready;
   logic         blk_en1;
   logic         blk_en2;
   logic         blk_en3;
   logic         blk_en4;
   logic [127:0] blk_data;
   logic         blk_first;
   logic         blk_last;
   logic         core_done;

   modport master (
      output s_data, s_valid, s_last, core_done,
      input  s_ready, blk_en1, blk_en2, blk_en3, blk_en4, blk_data, blk_first, blk_last
   );

   modport slave (
      input  s_data, s_valid, s_last, core_done,
      output s_ready, blk_en1, blk_en2, blk_en3, blk_en4, blk_data, blk_first, blk_last
   );
endinterface

// File: rtl/md5_block_feeder.sv
// MD5 front end: buffers message bytes into 64-byte blocks, applies padding and the
// bit-length trailer, and streams each block to the core as four 128-bit beats.
module md5_block_feeder #(
   parameter int unsigned LEN_W = 61
) (
   input  logic              clk,
   input  logic              reset,
   md5_block_feeder_if.slave bus
);
   typedef enum logic [2:0] {FILL, PAD, PAD0, LENBLK, SEND, WAIT} state_t;
   typedef enum logic [1:0] {TAIL_NONE, TAIL_PAD0, TAIL_LEN} tail_t;

   state_t           r_state, w_state_nxt;
   tail_t            r_tail, w_tail_nxt;
   logic [7:0]       r_buf [64];
   logic [7:0]       w_buf_nxt [64];
   logic [6:0]       r_n, w_n_nxt;
   logic [LEN_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [63:0]      r_len, w_len_nxt;
   logic [1:0]       r_beat, w_beat_nxt;
   logic             r_first, w_first_nxt;
   logic             r_fin, w_fin_nxt;
   logic             r_msg_end, w_msg_end_nxt;
   logic             w_acc, w_put_len;
   logic [127:0]     w_beat_data;

   logic             r_s_ready;
   logic [3:0]       r_blk_en;
   logic [127:0]     r_blk_data;
   logic             r_blk_first, r_blk_last;

   always_comb begin
      w_state_nxt   = r_state;
      w_tail_nxt    = r_tail;
      w_buf_nxt     = r_buf;
      w_n_nxt       = r_n;
      w_cnt_nxt     = r_cnt;
      w_len_nxt     = r_len;
      w_beat_nxt    = r_beat;
      w_first_nxt   = r_first;
      w_fin_nxt     = r_fin;
      w_msg_end_nxt = r_msg_end;
      w_put_len     = 1'b0;
      w_acc         = bus.s_valid && r_s_ready;
      w_cnt_inc     = r_cnt + LEN_W'(1);

      unique case (r_state)
         FILL: begin
            if (w_acc) begin
               w_buf_nxt[r_n[5:0]] = bus.s_data;
               w_n_nxt             = r_n + 7'd1;
               w_cnt_nxt           = w_cnt_inc;
               if (bus.s_last) begin
                  w_len_nxt     = 64'({w_cnt_inc, 3'b000});
                  w_msg_end_nxt = 1'b1;
                  if (w_n_nxt == 7'd64) begin
                     w_state_nxt = SEND;
                     w_tail_nxt  = TAIL_PAD0;
                     w_fin_nxt   = 1'b0;
                  end else begin
                     w_state_nxt = PAD;
                  end
               end else if (w_n_nxt == 7'd64) begin
                  w_state_nxt = SEND;
                  w_fin_nxt   = 1'b0;
               end
            end
         end
         PAD: begin
            for (int unsigned i = 0; i < 64; i++) begin
               if (i == 32'(r_n))     w_buf_nxt[i] = 8'h80;
               else if (i > 32'(r_n)) w_buf_nxt[i] = '0;
            end
            // Without 8 free bytes after the 0x80 marker the length goes in an extra block.
            if (r_n <= 7'd55) begin
               w_put_len = 1'b1;
               w_fin_nxt = 1'b1;
            end else begin
               w_tail_nxt = TAIL_LEN;
               w_fin_nxt  = 1'b0;
            end
            w_state_nxt = SEND;
         end
         PAD0, LENBLK: begin
            for (int unsigned i = 0; i < 64; i++) w_buf_nxt[i] = '0;
            if (r_state == PAD0) w_buf_nxt[0] = 8'h80;
            w_put_len   = 1'b1;
            w_fin_nxt   = 1'b1;
            w_state_nxt = SEND;
         end
         SEND: begin
            w_beat_nxt = r_beat + 2'd1;
            if (r_beat == 2'd3) begin
               w_state_nxt = WAIT;
               w_first_nxt = 1'b0;
            end
         end
         WAIT: begin
            if (bus.core_done) begin
               if (r_tail == TAIL_PAD0) begin
                  w_state_nxt = PAD0;
                  w_tail_nxt  = TAIL_NONE;
               end else if (r_tail == TAIL_LEN) begin
                  w_state_nxt = LENBLK;
                  w_tail_nxt  = TAIL_NONE;
               end else begin
                  w_state_nxt = FILL;
                  w_n_nxt     = '0;
                  if (r_msg_end) begin
                     w_cnt_nxt     = '0;
                     w_first_nxt   = 1'b1;
                     w_msg_end_nxt = 1'b0;
                  end
               end
            end
         end
         default: w_state_nxt = FILL;
      endcase

      if (w_put_len) begin
         for (int unsigned j = 0; j < 8; j++) w_buf_nxt[56 + j] = r_len[8*j +: 8];
      end
   end

   // Beat payload is taken from the next buffer image so the first beat sees same-edge pad writes.
   always_comb begin
      w_beat_data = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         w_beat_data[(3 - i/4)*32 + (i%4)*8 +: 8] = w_buf_nxt[{w_beat_nxt, 4'(i)}];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= FILL;
         r_tail      <= TAIL_NONE;
         for (int unsigned i = 0; i < 64; i++) r_buf[i] <= '0;
         r_n         <= '0;
         r_cnt       <= '0;
         r_len       <= '0;
         r_beat      <= '0;
         r_first     <= 1'b1;
         r_fin       <= 1'b0;
         r_msg_end   <= 1'b0;
         r_s_ready   <= 1'b0;
         r_blk_en    <= '0;
         r_blk_data  <= '0;
         r_blk_first <= 1'b0;
         r_blk_last  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_tail    <= w_tail_nxt;
         r_buf     <= w_buf_nxt;
         r_n       <= w_n_nxt;
         r_cnt     <= w_cnt_nxt;
         r_len     <= w_len_nxt;
         r_beat    <= w_beat_nxt;
         r_first   <= w_first_nxt;
         r_fin     <= w_fin_nxt;
         r_msg_end <= w_msg_end_nxt;
         r_s_ready <= (w_state_nxt == FILL);
         if (w_state_nxt == SEND) begin
            r_blk_en    <= 4'b0001 << w_beat_nxt;
            r_blk_data  <= w_beat_data;
            r_blk_first <= w_first_nxt;
            r_blk_last  <= w_fin_nxt;
         end else begin
            r_blk_en    <= '0;
            r_blk_data  <= '0;
            r_blk_first <= 1'b0;
            r_blk_last  <= 1'b0;
         end
      end
   end

   assign bus.s_ready   = r_s_ready;
   assign bus.blk_en1   = r_blk_en[0];
   assign bus.blk_en2   = r_blk_en[1];
   assign bus.blk_en3   = r_blk_en[2];
   assign bus.blk_en4   = r_blk_en[3];
   assign bus.blk_data  = r_blk_data;
   assign bus.blk_first = r_blk_first;
   assign bus.blk_last  = r_blk_last;
endmodule
